// File: rtl/reg_pair_write_arbiter_pkg.sv
// Shared types and constants for the register-pair write arbiter.
package reg_arb_pkg;

    // Clear sequence states; IDLE is the only state that accepts commands.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR_Q = 2'd1,
        CLR_R = 2'd2
    } state_e;

    // Target select encoding carried on req_sel.
    localparam logic SEL_Q = 1'b0;
    localparam logic SEL_R = 1'b1;

endpackage

// File: rtl/reg_pair_write_arbiter_if.sv
// Command bus between the requesters and the register-pair arbiter.
interface reg_pair_write_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_sel;
    logic [NREQ-1:0]       req_clr;
    logic [NREQ*WIDTH-1:0] req_data;

    // Requester side drives commands and observes accept.
    modport master (
        output req_valid, req_sel, req_clr, req_data,
        input  req_ready
    );

    // Arbiter side observes commands and drives accept.
    modport slave (
        input  req_valid, req_sel, req_clr, req_data,
        output req_ready
    );
endinterface

// File: rtl/reg_pair_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt_oh,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);
    localparam int IW = $clog2(NREQ);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk candidates ptr+1 .. ptr+NREQ (mod NREQ); first valid one wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            sum = {1'b0, ptr} + (IW+1)'(off);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt_oh[cand] = 1'b1;
                gnt_idx      = cand;
            end
        end
    end
endmodule

// File: rtl/reg_pair_write_arbiter.sv
// Round-robin arbiter owning the shared q/r register pair.
//
// state | meaning
// IDLE  | accepting commands; writes complete in one edge
// CLR_Q | clear accepted; q is zeroed on the next edge
// CLR_R | q zeroed; r is zeroed on the next edge, then back to IDLE
module reg_pair_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    reg_pair_write_arbiter_if.slave  bus,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         r,
    output logic                     busy,
    output logic                     wr_done,
    output logic [$clog2(NREQ)-1:0]  gnt_id
);
    localparam int IW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  q_val_q, q_val_d;
    logic [WIDTH-1:0]  r_val_q, r_val_d;
    logic              wr_done_q, wr_done_d;
    logic [IW-1:0]     gnt_id_q, gnt_id_d;

    logic [NREQ-1:0]   gnt_oh;
    logic [IW-1:0]     gnt_idx;
    logic [NREQ-1:0]   ready;
    logic              accept;
    logic [WIDTH-1:0]  data_arr [NREQ];
    logic [WIDTH-1:0]  win_data;
    logic              win_sel;
    logic              win_clr;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    for (genvar g = 0; g < NREQ; g++) begin : g_data
        assign data_arr[g] = bus.req_data[g*WIDTH +: WIDTH];
    end

    assign ready         = (state_q == IDLE) ? gnt_oh : '0;
    assign accept        = |(bus.req_valid & ready);
    assign win_data      = data_arr[gnt_idx];
    assign win_sel       = bus.req_sel[gnt_idx];
    assign win_clr       = bus.req_clr[gnt_idx];
    assign bus.req_ready = ready;

    // Next-state: accept in IDLE, then step the clear sequence q before r.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        q_val_d   = q_val_q;
        r_val_d   = r_val_q;
        wr_done_d = 1'b0;
        gnt_id_d  = gnt_id_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d    = gnt_idx;
                    gnt_id_d = gnt_idx;
                    if (win_clr) begin
                        state_d = CLR_Q;
                    end else begin
                        wr_done_d = 1'b1;
                        if (win_sel == SEL_R) r_val_d = win_data;
                        else                  q_val_d = win_data;
                    end
                end
            end
            CLR_Q: begin
                q_val_d = '0;
                state_d = CLR_R;
            end
            CLR_R: begin
                r_val_d   = '0;
                wr_done_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register-pair flops; pointer resets so requester 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NREQ - 1);
            q_val_q   <= '0;
            r_val_q   <= '0;
            wr_done_q <= 1'b0;
            gnt_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            q_val_q   <= q_val_d;
            r_val_q   <= r_val_d;
            wr_done_q <= wr_done_d;
            gnt_id_q  <= gnt_id_d;
        end
    end

    assign q       = q_val_q;
    assign r       = r_val_q;
    assign busy    = (state_q == CLR_Q) || (state_q == CLR_R);
    assign wr_done = wr_done_q;
    assign gnt_id  = gnt_id_q;
endmodule

// File: tb/tb_reg_pair_write_arbiter.sv
// Directed bench for reg_pair_write_arbiter with a per-cycle reference model.
module tb_reg_pair_write_arbiter;
    localparam int W  = 8;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [NR-1:0]   valid, sel, clr;
    logic [NR*W-1:0] data;

    logic [W-1:0] q, r;
    logic         busy, wr_done;
    logic [0:0]   gnt_id;

    int n_pass = 0;
    int n_total = 0;

    reg_pair_write_arbiter_if #(.WIDTH(W), .NREQ(NR)) bus ();

    assign bus.req_valid = valid;
    assign bus.req_sel   = sel;
    assign bus.req_clr   = clr;
    assign bus.req_data  = data;

    reg_pair_write_arbiter #(.WIDTH(W), .NREQ(NR)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .q       (q),
        .r       (r),
        .busy    (busy),
        .wr_done (wr_done),
        .gnt_id  (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: register values, remaining clear steps, last winner.
    int m_q, m_r, m_clr_left, m_last, m_gnt;
    bit m_done;

    initial begin : model_cmp
        int win, nd;
        logic [NR-1:0] exp_ready;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_q = 0; m_r = 0; m_clr_left = 0; m_last = NR - 1; m_gnt = 0; m_done = 0;
            end
            exp_ready = '0;
            win = -1;
            if (m_clr_left == 0) begin
                for (int k = 1; k <= NR; k++) begin
                    if (win < 0 && valid[(m_last + k) % NR]) win = (m_last + k) % NR;
                end
                if (win >= 0) exp_ready[win] = 1'b1;
            end
            chk("cmp_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("cmp_q", 32'(q), 32'(m_q));
            chk("cmp_r", 32'(r), 32'(m_r));
            chk("cmp_busy", 32'(busy), 32'(m_clr_left != 0));
            chk("cmp_wr_done", 32'(wr_done), 32'(m_done));
            chk("cmp_gnt_id", 32'(gnt_id), 32'(m_gnt));
            if (rst_n) begin
                nd = 0;
                if (m_clr_left == 2) begin
                    m_q = 0; m_clr_left = 1;
                end else if (m_clr_left == 1) begin
                    m_r = 0; m_clr_left = 0; nd = 1;
                end else if (win >= 0) begin
                    m_last = win; m_gnt = win;
                    if (clr[win]) m_clr_left = 2;
                    else begin
                        if (sel[win]) m_r = int'(data[win*W +: W]);
                        else          m_q = int'(data[win*W +: W]);
                        nd = 1;
                    end
                end
                m_done = (nd != 0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        rst_n = 1'b0; valid = '0; sel = '0; clr = '0; data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_r", 32'(r), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);

        // single write q=A5 from req0
        tick(); valid[0] = 1; sel[0] = 0; data[7:0] = 8'hA5;
        @(negedge clk); chk("wr1_ready", 32'(bus.req_ready), 32'b01);
        tick(); valid[0] = 0;
        @(negedge clk);
        chk("wr1_q", 32'(q), 32'hA5);
        chk("wr1_r", 32'(r), 32'h00);
        chk("wr1_done", 32'(wr_done), 32'd1);
        chk("wr1_gnt", 32'(gnt_id), 32'd0);
        tick(); @(negedge clk); chk("wr1_done_end", 32'(wr_done), 32'd0);

        // req1 writes q=77 so req0 is next in line
        tick(); valid[1] = 1; sel[1] = 0; data[15:8] = 8'h77;
        @(negedge clk); chk("wr2_ready", 32'(bus.req_ready), 32'b10);
        tick(); valid[1] = 0;
        @(negedge clk); chk("wr2_q", 32'(q), 32'h77);

        // fairness: both write r
        tick(); valid = 2'b11; sel = 2'b11; data = {8'h22, 8'h11};
        @(negedge clk); chk("fair_ready0", 32'(bus.req_ready), 32'b01);
        tick(); valid[0] = 0;
        @(negedge clk);
        chk("fair_r11", 32'(r), 32'h11);
        chk("fair_gnt0", 32'(gnt_id), 32'd0);
        chk("fair_ready1", 32'(bus.req_ready), 32'b10);
        tick(); valid[1] = 0;
        @(negedge clk);
        chk("fair_r22", 32'(r), 32'h22);
        chk("fair_gnt1", 32'(gnt_id), 32'd1);

        // clear sequencing with q=5A r=3C
        tick(); valid[0] = 1; sel[0] = 0; data[7:0] = 8'h5A;
        tick(); valid[0] = 0; valid[1] = 1; sel[1] = 1; data[15:8] = 8'h3C;
        tick(); clr[1] = 1;
        @(negedge clk);
        chk("clr_pre_q", 32'(q), 32'h5A);
        chk("clr_pre_r", 32'(r), 32'h3C);
        chk("clr_ready", 32'(bus.req_ready), 32'b10);
        tick(); valid[1] = 0; clr[1] = 0; valid[0] = 1; sel[0] = 0; data[7:0] = 8'h99;
        @(negedge clk);
        chk("clr1_busy", 32'(busy), 32'd1);
        chk("clr1_q", 32'(q), 32'h5A);
        chk("clr1_ready", 32'(bus.req_ready), 32'd0);
        tick(); @(negedge clk);
        chk("clr2_busy", 32'(busy), 32'd1);
        chk("clr2_q", 32'(q), 32'h00);
        chk("clr2_r", 32'(r), 32'h3C);
        chk("clr2_ready", 32'(bus.req_ready), 32'd0);
        tick(); @(negedge clk);
        chk("clr3_busy", 32'(busy), 32'd0);
        chk("clr3_r", 32'(r), 32'h00);
        chk("clr3_done", 32'(wr_done), 32'd1);
        chk("clr3_ready", 32'(bus.req_ready), 32'b01);
        chk("clr3_gnt", 32'(gnt_id), 32'd1);
        tick(); valid[0] = 0;
        @(negedge clk);
        chk("clr4_q", 32'(q), 32'h99);
        chk("clr4_gnt", 32'(gnt_id), 32'd0);

        // reset during CLR_Q
        tick(); valid[1] = 1; sel[1] = 1; data[15:8] = 8'h66;
        tick(); clr[1] = 1;
        @(negedge clk);
        chk("rmc_r", 32'(r), 32'h66);
        chk("rmc_ready", 32'(bus.req_ready), 32'b10);
        tick(); valid[1] = 0; clr[1] = 0; rst_n = 1'b0;
        @(negedge clk);
        chk("rmc_q", 32'(q), 32'h00);
        chk("rmc_r0", 32'(r), 32'h00);
        chk("rmc_busy", 32'(busy), 32'd0);
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("rmc_done", 32'(wr_done), 32'd0);
        chk("rmc_busy2", 32'(busy), 32'd0);
        tick(); valid = 2'b11; sel = 2'b10; data = {8'h55, 8'h44};
        @(negedge clk); chk("rmc_first", 32'(bus.req_ready), 32'b01);
        tick(); valid[0] = 0;
        @(negedge clk); chk("rmc_q44", 32'(q), 32'h44);
        tick(); valid[1] = 0;
        @(negedge clk); chk("rmc_r55", 32'(r), 32'h55);

        // back-to-back writes from req0
        tick(); valid[0] = 1; sel[0] = 0; data[7:0] = 8'h01;
        @(negedge clk); chk("b2b_ready0", 32'(bus.req_ready), 32'b01);
        for (int i = 2; i <= 3; i++) begin
            tick(); data[7:0] = 8'(i);
            @(negedge clk);
            chk("b2b_ready", 32'(bus.req_ready), 32'b01);
            chk("b2b_q", 32'(q), 32'(i - 1));
            chk("b2b_done", 32'(wr_done), 32'd1);
        end
        tick(); valid[0] = 0;
        @(negedge clk);
        chk("b2b_q3", 32'(q), 32'h03);
        chk("b2b_done3", 32'(wr_done), 32'd1);
        tick(); @(negedge clk);
        chk("b2b_done_end", 32'(wr_done), 32'd0);

        repeat (3) tick();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_pair_write_arbiter.md
Name: reg_pair_write_arbiter

Overview:
- Shares one pair of WIDTH-bit state registers (q, r) between NREQ requesters.
- Each requester issues single-beat write or clear commands over a valid/ready handshake.
- A round-robin arbiter picks one requester per cycle.
- A small FSM sequences a clear command as two ordered register updates, q first, then r.
- The block sits between command sources and the shared register pair and is the only writer of q and r.

Parameters:
- WIDTH, 8, data width of q, r and the request data.
- NREQ, 2, number of requesters (2..8).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_sel  in  NREQ  per-requester target select: 0 writes q, 1 writes r; ignored for clear.
- req_clr  in  NREQ  per-requester clear command; 1 clears both registers.
- req_data  in  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- q  out  WIDTH  shared register 0.
- r  out  WIDTH  shared register 1.
- busy  out  1  high while a clear sequence is in progress.
- wr_done  out  1  one-cycle pulse the cycle after any write, or after a completed clear.
- gnt_id  out  $clog2(NREQ)  index of the last accepted requester.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - q=0, r=0, busy=0, wr_done=0, gnt_id=0.
  - State=IDLE.
  - Round-robin pointer is set to NREQ-1, so requester 0 has top priority first.
- req_ready is combinational: one-hot of the arbiter winner when state==IDLE, all zero otherwise.
- Arbitration:
  - Round-robin over req_valid, searching from pointer+1 upward with wrap.
  - The pointer updates to the winner only on an accepted transfer (valid & ready).
- Handshake rules:
  - Requester keeps valid, sel, clr and data stable until ready.
  - A requester may not be granted two consecutive transfers while another requester is valid.
- Write (accepted, clr=0):
  - sel=0: q <= data at that edge. sel=1: r <= data at that edge.
  - New value is visible the next cycle; the other register holds.
  - wr_done pulses the following cycle; state stays IDLE, so back-to-back writes run every cycle.
- Clear (accepted, clr=1): state -> CLR_Q.
  - CLR_Q: busy=1, ready=0; next edge q<=0, state -> CLR_R.
  - CLR_R: busy=1, ready=0; next edge r<=0, state -> IDLE, wr_done pulses the cycle after.
  - Total: 3 edges from accept to IDLE.
  - clr has priority over sel for the accepted requester.
- FSM states: IDLE, CLR_Q, CLR_R. Illegal encodings recover to IDLE.
- gnt_id is registered on each accept.
- No valid inputs: registers hold, no pulse.
- Reset asserted mid-clear: immediate return to IDLE with both registers 0. The aborted clear is not resumed and produces no wr_done.
- Only one register is written per edge; a write and a clear step never occur in the same cycle.

Decomposition:
- Shared package reg_arb_pkg:
  - state_e enum {IDLE, CLR_Q, CLR_R}.
  - Select constants SEL_Q=1'b0, SEL_R=1'b1.
- One sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, binary index.
  - Purely combinational; the pointer register lives in the top.

Test Plan:
- Reset: after release, q=0x00, r=0x00, busy=0, req_ready=0 with no valid.
- Single write: req0 valid, sel=0, data=0xA5 -> ready0=1 the same cycle; q=0xA5 next cycle, r unchanged; wr_done one-cycle pulse; gnt_id=0.
- Fairness: req0 and req1 both hold valid with writes to r (0x11, 0x22), each dropping valid after its accept -> accept order req0, req1; r=0x11 then 0x22; gnt_id 0 then 1.
- Clear sequencing: q=0x5A, r=0x3C, req1 clr=1 -> accept, then q=0 one edge later, r=0 the next, busy high for exactly 2 cycles; req0 valid during busy sees ready0=0 and is accepted on return to IDLE.
- Reset mid-clear: assert rst_n=0 in CLR_Q -> q=r=0, state IDLE, no wr_done; first post-reset grant goes to req0.
- Back-to-back writes: req0 writes q=0x01, 0x02, 0x03 on consecutive cycles with req1 idle -> ready0 high every cycle; q follows with 1-cycle latency; wr_done high 3 cycles.
